// File: rtl/line_storer.sv
// Line storer: buffers an 8-bit pixel stream one line at a time in two ping-pong
// banks and writes each completed line to memory as a single AXI4 INCR burst.
module line_storer #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_DA = 32,
    parameter int WIDTH        = 128,
    parameter int HEIGHT       = 128
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      store_start,
    input  logic [AXI_WIDTH_AD-1:0]   base_addr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AXI_WIDTH_DA-1:0]   in_data,
    output logic                      m_axi_memory_bus_AWVALID,
    input  logic                      m_axi_memory_bus_AWREADY,
    output logic [AXI_WIDTH_AD-1:0]   m_axi_memory_bus_AWADDR,
    output logic [AXI_WIDTH_ID-1:0]   m_axi_memory_bus_AWID,
    output logic [7:0]                m_axi_memory_bus_AWLEN,
    output logic [2:0]                m_axi_memory_bus_AWSIZE,
    output logic [1:0]                m_axi_memory_bus_AWBURST,
    output logic                      m_axi_memory_bus_WVALID,
    input  logic                      m_axi_memory_bus_WREADY,
    output logic [AXI_WIDTH_DA-1:0]   m_axi_memory_bus_WDATA,
    output logic [AXI_WIDTH_DA/8-1:0] m_axi_memory_bus_WSTRB,
    output logic                      m_axi_memory_bus_WLAST,
    input  logic                      m_axi_memory_bus_BVALID,
    output logic                      m_axi_memory_bus_BREADY,
    input  logic [1:0]                m_axi_memory_bus_BRESP,
    output logic                      busy,
    output logic                      store_done,
    output logic                      store_err
);

    localparam int WPL = WIDTH * 8 / AXI_WIDTH_DA;
    localparam int CW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int LW  = $clog2(HEIGHT + 1);
    localparam int SW  = AXI_WIDTH_DA / 8;

    localparam logic [CW-1:0]           LAST_WORD  = CW'(WPL - 1);
    localparam logic [CW-1:0]           WORD_ZERO  = {CW{1'b0}};
    localparam logic [LW-1:0]           LAST_LINE  = LW'(HEIGHT - 1);
    localparam logic [LW-1:0]           NUM_LINES  = LW'(HEIGHT);
    localparam logic [AXI_WIDTH_AD-1:0] LINE_BYTES = AXI_WIDTH_AD'(WIDTH);
    localparam logic [AXI_WIDTH_AD-1:0] ADDR_ZERO  = {AXI_WIDTH_AD{1'b0}};
    localparam logic [AXI_WIDTH_DA-1:0] DATA_ZERO  = {AXI_WIDTH_DA{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    // Frame-control and fill-side state
    logic                    busy_r;
    logic                    store_done_r;
    logic                    store_err_r;
    logic                    in_ready_r;
    logic [AXI_WIDTH_AD-1:0] line_addr_r;
    logic [LW-1:0]           line_idx_r;
    logic [LW-1:0]           lines_filled_r;
    logic [1:0]              full_r;
    logic                    fill_sel_r;
    logic                    drain_sel_r;
    logic [CW-1:0]           wcnt_r;

    logic                    busy_nxt_s;
    logic                    store_done_nxt_s;
    logic                    store_err_nxt_s;
    logic                    in_ready_nxt_s;
    logic [AXI_WIDTH_AD-1:0] line_addr_nxt_s;
    logic [LW-1:0]           line_idx_nxt_s;
    logic [LW-1:0]           lines_filled_nxt_s;
    logic [1:0]              full_nxt_s;
    logic                    fill_sel_nxt_s;
    logic                    drain_sel_nxt_s;
    logic [CW-1:0]           wcnt_nxt_s;

    // Drain-side state
    logic [1:0]              drain_state_r;
    logic                    awvalid_r;
    logic [AXI_WIDTH_AD-1:0] awaddr_r;
    logic                    wvalid_r;
    logic [AXI_WIDTH_DA-1:0] wdata_r;
    logic                    wlast_r;
    logic                    bready_r;
    logic [CW-1:0]           bcnt_r;
    logic [CW-1:0]           bcnt_nxt_s;

    logic [AXI_WIDTH_DA-1:0] bank_mem [0:1][0:WPL-1];

    logic start_s;
    logic in_hs_s;
    logic fill_last_s;
    logic b_hs_s;
    logic frame_end_s;

    assign start_s     = store_start & ~busy_r;
    assign in_hs_s     = in_valid & in_ready_r;
    assign fill_last_s = in_hs_s & (wcnt_r == LAST_WORD);
    assign b_hs_s      = bready_r & m_axi_memory_bus_BVALID;
    assign frame_end_s = b_hs_s & (line_idx_r == LAST_LINE);
    assign bcnt_nxt_s  = bcnt_r + CW'(1);

    // Next-state for frame control, fill counters and bank full flags
    always_comb begin
        busy_nxt_s         = busy_r;
        store_done_nxt_s   = 1'b0;
        store_err_nxt_s    = store_err_r;
        line_addr_nxt_s    = line_addr_r;
        line_idx_nxt_s     = line_idx_r;
        lines_filled_nxt_s = lines_filled_r;
        full_nxt_s         = full_r;
        fill_sel_nxt_s     = fill_sel_r;
        drain_sel_nxt_s    = drain_sel_r;
        wcnt_nxt_s         = wcnt_r;

        if (start_s) begin
            busy_nxt_s         = 1'b1;
            store_err_nxt_s    = 1'b0;
            line_addr_nxt_s    = base_addr;
            line_idx_nxt_s     = {LW{1'b0}};
            lines_filled_nxt_s = {LW{1'b0}};
            full_nxt_s         = 2'b00;
            fill_sel_nxt_s     = 1'b0;
            drain_sel_nxt_s    = 1'b0;
            wcnt_nxt_s         = WORD_ZERO;
        end else begin
            if (in_hs_s) begin
                if (fill_last_s) begin
                    full_nxt_s[fill_sel_r] = 1'b1;
                    fill_sel_nxt_s         = ~fill_sel_r;
                    wcnt_nxt_s             = WORD_ZERO;
                    lines_filled_nxt_s     = lines_filled_r + LW'(1);
                end else begin
                    wcnt_nxt_s = wcnt_r + CW'(1);
                end
            end else begin
                wcnt_nxt_s = wcnt_r;
            end

            // Fill and drain never touch the same bank flag in one cycle
            if (b_hs_s) begin
                full_nxt_s[drain_sel_r] = 1'b0;
                drain_sel_nxt_s         = ~drain_sel_r;
                line_idx_nxt_s          = line_idx_r + LW'(1);
                line_addr_nxt_s         = line_addr_r + LINE_BYTES;
                if (m_axi_memory_bus_BRESP != 2'b00) begin
                    store_err_nxt_s = 1'b1;
                end else begin
                    store_err_nxt_s = store_err_r;
                end
            end else begin
                drain_sel_nxt_s = drain_sel_r;
            end

            if (frame_end_s) begin
                busy_nxt_s       = 1'b0;
                store_done_nxt_s = 1'b1;
            end else begin
                busy_nxt_s       = busy_r;
                store_done_nxt_s = 1'b0;
            end
        end

        in_ready_nxt_s = busy_nxt_s & ~full_nxt_s[fill_sel_nxt_s]
                       & (lines_filled_nxt_s < NUM_LINES);
    end

    // Frame-control state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            busy_r         <= 1'b0;
            store_done_r   <= 1'b0;
            store_err_r    <= 1'b0;
            in_ready_r     <= 1'b0;
            line_addr_r    <= ADDR_ZERO;
            line_idx_r     <= {LW{1'b0}};
            lines_filled_r <= {LW{1'b0}};
            full_r         <= 2'b00;
            fill_sel_r     <= 1'b0;
            drain_sel_r    <= 1'b0;
            wcnt_r         <= WORD_ZERO;
        end else begin
            busy_r         <= busy_nxt_s;
            store_done_r   <= store_done_nxt_s;
            store_err_r    <= store_err_nxt_s;
            in_ready_r     <= in_ready_nxt_s;
            line_addr_r    <= line_addr_nxt_s;
            line_idx_r     <= line_idx_nxt_s;
            lines_filled_r <= lines_filled_nxt_s;
            full_r         <= full_nxt_s;
            fill_sel_r     <= fill_sel_nxt_s;
            drain_sel_r    <= drain_sel_nxt_s;
            wcnt_r         <= wcnt_nxt_s;
        end
    end

    // Line bank write port; contents are don't-care until written
    always_ff @(posedge ap_clk) begin
        if (in_hs_s) begin
            bank_mem[fill_sel_r][wcnt_r] <= in_data;
        end
    end

    // Drain FSM: one AW, WPL beats, one B per line; W data prefetched into wdata_r
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            drain_state_r <= ST_IDLE;
            awvalid_r     <= 1'b0;
            awaddr_r      <= ADDR_ZERO;
            wvalid_r      <= 1'b0;
            wdata_r       <= DATA_ZERO;
            wlast_r       <= 1'b0;
            bready_r      <= 1'b0;
            bcnt_r        <= WORD_ZERO;
        end else begin
            case (drain_state_r)
                ST_IDLE: begin
                    if (busy_r && full_r[drain_sel_r]) begin
                        drain_state_r <= ST_AW;
                        awvalid_r     <= 1'b1;
                        awaddr_r      <= line_addr_r;
                    end else begin
                        drain_state_r <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (m_axi_memory_bus_AWREADY) begin
                        drain_state_r <= ST_W;
                        awvalid_r     <= 1'b0;
                        wvalid_r      <= 1'b1;
                        wdata_r       <= bank_mem[drain_sel_r][WORD_ZERO];
                        wlast_r       <= (LAST_WORD == WORD_ZERO);
                        bcnt_r        <= WORD_ZERO;
                    end else begin
                        drain_state_r <= ST_AW;
                    end
                end
                ST_W: begin
                    if (m_axi_memory_bus_WREADY) begin
                        if (wlast_r) begin
                            drain_state_r <= ST_B;
                            wvalid_r      <= 1'b0;
                            wlast_r       <= 1'b0;
                            bready_r      <= 1'b1;
                        end else begin
                            bcnt_r  <= bcnt_nxt_s;
                            wdata_r <= bank_mem[drain_sel_r][bcnt_nxt_s];
                            wlast_r <= (bcnt_nxt_s == LAST_WORD);
                        end
                    end else begin
                        drain_state_r <= ST_W;
                    end
                end
                ST_B: begin
                    if (m_axi_memory_bus_BVALID) begin
                        drain_state_r <= ST_IDLE;
                        bready_r      <= 1'b0;
                    end else begin
                        drain_state_r <= ST_B;
                    end
                end
                default: begin
                    drain_state_r <= ST_IDLE;
                    awvalid_r     <= 1'b0;
                    wvalid_r      <= 1'b0;
                    wlast_r       <= 1'b0;
                    bready_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready                 = in_ready_r;
    assign busy                     = busy_r;
    assign store_done               = store_done_r;
    assign store_err                = store_err_r;
    assign m_axi_memory_bus_AWVALID = awvalid_r;
    assign m_axi_memory_bus_AWADDR  = awaddr_r;
    assign m_axi_memory_bus_AWID    = {AXI_WIDTH_ID{1'b0}};
    assign m_axi_memory_bus_AWLEN   = 8'(WPL - 1);
    assign m_axi_memory_bus_AWSIZE  = 3'($clog2(SW));
    assign m_axi_memory_bus_AWBURST = 2'b01;
    assign m_axi_memory_bus_WVALID  = wvalid_r;
    assign m_axi_memory_bus_WDATA   = wdata_r;
    assign m_axi_memory_bus_WSTRB   = {SW{1'b1}};
    assign m_axi_memory_bus_WLAST   = wlast_r;
    assign m_axi_memory_bus_BREADY  = bready_r;

endmodule

// File: tb/tb_line_storer.sv
// Directed bench for line_storer (16-pixel lines, 4 lines, 4 words per line) with
// a small AXI write slave that stores beats into a local memory image.
module tb_line_storer;

    localparam int WPL = 4;
    localparam int NW  = 16;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        store_start;
    logic [31:0] base_addr;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        busy, store_done, store_err;

    always #5 ap_clk = ~ap_clk;

    line_storer #(
        .AXI_WIDTH_AD(32), .AXI_WIDTH_ID(4), .AXI_WIDTH_DA(32), .WIDTH(16), .HEIGHT(4)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .store_start(store_start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .m_axi_memory_bus_AWVALID(awvalid), .m_axi_memory_bus_AWREADY(awready),
        .m_axi_memory_bus_AWADDR(awaddr), .m_axi_memory_bus_AWID(awid),
        .m_axi_memory_bus_AWLEN(awlen), .m_axi_memory_bus_AWSIZE(awsize),
        .m_axi_memory_bus_AWBURST(awburst),
        .m_axi_memory_bus_WVALID(wvalid), .m_axi_memory_bus_WREADY(wready),
        .m_axi_memory_bus_WDATA(wdata), .m_axi_memory_bus_WSTRB(wstrb),
        .m_axi_memory_bus_WLAST(wlast),
        .m_axi_memory_bus_BVALID(bvalid), .m_axi_memory_bus_BREADY(bready),
        .m_axi_memory_bus_BRESP(bresp),
        .busy(busy), .store_done(store_done), .store_err(store_err)
    );

    int n_checks, n_errors;

    int aw_delay, aw_wait, b_delay0, b_wait, err_line, b_line, beat, n_bursts;
    int src_idx, acc_obs, done_cnt, pp_gap;
    bit w_toggle, w_phase, aw_open, aw_stall_prev, w_stall_prev, src_en;
    bit in_ready_obs, b0_hs_now, b0_prev, err_at_done, pp_mode, pp_full_seen, pp_b0_seen;
    logic [31:0] aw_prev_addr, w_prev_data, cur_addr;
    logic        w_prev_last;
    logic [31:0] addr_log [0:7];
    logic [31:0] src [0:15];
    logic [31:0] mem [0:4095];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bench_clear();
        aw_wait = 0; b_wait = 0; b_line = 0; beat = 0; n_bursts = 0;
        src_idx = 0; acc_obs = 0; done_cnt = 0; pp_gap = 0;
        w_phase = 1'b0; aw_open = 1'b0; aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
        b0_hs_now = 1'b0; b0_prev = 1'b0; err_at_done = 1'b0;
        pp_full_seen = 1'b0; pp_b0_seen = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        in_valid = 1'b0; in_data = 32'h0;
    endtask

    // One clock: observe at the falling edge, then drive slave and source inputs
    task automatic tick();
        logic [11:0] idx;
        @(negedge ap_clk);
        if (store_done) begin
            done_cnt++;
            err_at_done = store_err;
            check("done_busy_low", 32'(busy), 32'd0);
        end
        if (aw_stall_prev) begin
            check("aw_hold_valid", 32'(awvalid), 32'd1);
            check("aw_hold_addr", awaddr, aw_prev_addr);
        end
        if (w_stall_prev) begin
            check("w_hold_valid", 32'(wvalid), 32'd1);
            check("w_hold_data", wdata, w_prev_data);
            check("w_hold_last", 32'(wlast), 32'(w_prev_last));
        end

        awready = awvalid && (aw_wait >= aw_delay);
        aw_stall_prev = awvalid && !awready;
        aw_prev_addr = awaddr;
        if (awvalid && !awready) aw_wait++;
        if (awvalid && awready) begin
            if (n_bursts < 8) addr_log[n_bursts] = awaddr;
            n_bursts++;
            check("awlen", 32'(awlen), 32'd3);
            check("awsize", 32'(awsize), 32'd2);
            check("awburst", 32'(awburst), 32'd1);
            check("awid", 32'(awid), 32'd0);
            cur_addr = awaddr; beat = 0; aw_open = 1'b1; aw_wait = 0;
        end

        if (wvalid) check("w_after_aw", 32'(aw_open), 32'd1);
        wready = w_toggle ? w_phase : 1'b1;
        w_phase = !w_phase;
        w_stall_prev = wvalid && !wready;
        w_prev_data = wdata;
        w_prev_last = wlast;
        if (wvalid && wready) begin
            idx = 12'((cur_addr >> 2) + 32'(beat));
            mem[idx] = wdata;
            check("wlast", 32'(wlast), 32'(beat == WPL - 1));
            check("wstrb", 32'(wstrb), 32'hF);
            beat++;
            if (wlast) aw_open = 1'b0;
        end

        b0_hs_now = 1'b0;
        if (bready) begin
            bvalid = (b_wait >= ((b_line == 0) ? b_delay0 : 0));
            bresp = (b_line == err_line) ? 2'b10 : 2'b00;
            if (!bvalid) b_wait++;
        end else begin
            bvalid = 1'b0;
            bresp = 2'b00;
        end
        if (bready && bvalid) begin
            b0_hs_now = (b_line == 0);
            b_line++;
            b_wait = 0;
        end

        in_ready_obs = in_ready;
        acc_obs = src_idx;
        in_valid = src_en && (src_idx < NW);
        in_data = (src_idx < NW) ? src[4'(src_idx)] : 32'h0;
        if (in_valid && in_ready) src_idx++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(store_done), 32'd0);
        check({tag, "_err"}, 32'(store_err), 32'd0);
        check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
        check({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        check({tag, "_bready"}, 32'(bready), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_awaddr"}, awaddr, 32'h0);
        check({tag, "_wlast"}, 32'(wlast), 32'd0);
    endtask

    task automatic start_frame(input logic [31:0] addr, input int k);
        for (int i = 0; i < NW; i++) src[i] = 32'hC0DE_0000 + 32'(k << 8) + 32'(i * 3 + 1);
        bench_clear();
        src_en = 1'b1;
        base_addr = addr;
        store_start = 1'b1;
        tick();
        store_start = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] base, input string tag);
        int n;
        logic [11:0] idx;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            tick();
            n++;
            if (pp_mode) begin
                if (b0_prev) begin
                    check("pp_ready_after_b0", 32'(in_ready_obs), 32'd1);
                    pp_b0_seen = 1'b1;
                end
                if (b0_hs_now) check("pp_ready_at_b0", 32'(in_ready_obs), 32'd0);
                if (acc_obs < 8 && !in_ready_obs) pp_gap++;
                if (acc_obs == 8 && !pp_full_seen) begin
                    check("pp_stall_after_8", 32'(in_ready_obs), 32'd0);
                    pp_full_seen = 1'b1;
                end
                b0_prev = b0_hs_now;
            end
        end
        check({tag, "_timeout"}, 32'(done_cnt > 0), 32'd1);
        repeat (5) tick();
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_bursts"}, 32'(n_bursts), 32'd4);
        for (int i = 0; i < 4; i++) check({tag, "_awaddr"}, addr_log[i], base + 32'(16 * i));
        for (int i = 0; i < NW; i++) begin
            idx = 12'((base >> 2) + 32'(i));
            check({tag, "_mem"}, mem[idx], src[i]);
        end
    endtask

    initial begin
        int n;
        n_checks = 0; n_errors = 0;
        store_start = 1'b0; base_addr = 32'h0; src_en = 1'b0;
        aw_delay = 0; b_delay0 = 0; err_line = 99; w_toggle = 1'b0; pp_mode = 1'b0;
        bench_clear();
        ap_rst_n = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        ap_rst_n = 1'b1;
        tick();

        start_frame(32'h1000, 1);
        run_frame(32'h1000, "basic");
        check("basic_err", 32'(err_at_done), 32'd0);

        aw_delay = 5; w_toggle = 1'b1;
        start_frame(32'h1000, 2);
        run_frame(32'h1000, "bp");
        aw_delay = 0; w_toggle = 1'b0;

        b_delay0 = 20; pp_mode = 1'b1;
        start_frame(32'h1000, 3);
        run_frame(32'h1000, "pp");
        check("pp_gap", 32'(pp_gap), 32'd0);
        check("pp_full_seen", 32'(pp_full_seen), 32'd1);
        check("pp_b0_seen", 32'(pp_b0_seen), 32'd1);
        b_delay0 = 0; pp_mode = 1'b0;

        err_line = 2;
        start_frame(32'h1000, 4);
        run_frame(32'h1000, "err");
        check("err_at_done", 32'(err_at_done), 32'd1);
        check("err_sticky", 32'(store_err), 32'd1);
        err_line = 99;

        start_frame(32'h3000, 5);
        check("err_cleared", 32'(store_err), 32'd0);
        n = 0;
        while (!(wvalid && beat >= 1) && n < 200) begin
            tick();
            n++;
        end
        check("midburst_reached", 32'(wvalid && beat >= 1), 32'd1);
        ap_rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        ap_rst_n = 1'b1;
        bench_clear();
        tick();
        check_reset_values("postrst");

        start_frame(32'h2000, 6);
        repeat (6) tick();
        check("busy_before_ignored_start", 32'(busy), 32'd1);
        base_addr = 32'h7000;
        store_start = 1'b1;
        tick();
        store_start = 1'b0;
        run_frame(32'h2000, "post_rst");
        check("post_rst_err", 32'(err_at_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
